// File: rtl/tomasulo_rs_arith.sv
// Arithmetic reservation station: holds ADD/SUB/MOV ops until their operands arrive and
// issues the oldest ready op. Each entry owns a CDB tag and is kept until that tag is broadcast.
package tomasulo_rs_arith_pkg;
  localparam int TAG_W   = 4;
  localparam int WORD_W  = 32;
  localparam int ROBID_W = 5;
  localparam int REG_W   = 5;

  typedef logic [1:0]         opcode_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [ROBID_W-1:0] robid_t;
  typedef logic [REG_W-1:0]   reg_t;

  localparam opcode_t OP_ADD = 2'd0;
  localparam opcode_t OP_SUB = 2'd1;
  localparam opcode_t OP_MOV = 2'd2;

  typedef struct packed {
    logic   vld;
    tag_t   tag;
    word_t  wdata;
    robid_t robid;
    reg_t   wa;
  } cdb_t;

  typedef struct packed {
    opcode_t     op;
    tag_t        tag;
    word_t [1:0] rdata;
    robid_t      robid;
    reg_t        wa;
  } issue_t;
endpackage

// state     | meaning
// ST_FREE   | entry unused, allocatable
// ST_WAIT   | at least one operand pending on the CDB
// ST_READY  | both operands held, eligible for select
// ST_ISSUED | issued, waiting for its own tag on the CDB
module tomasulo_rs_arith
  import tomasulo_rs_arith_pkg::*;
#(
  parameter int N        = 4,
  parameter int TAG_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_vld,
  input  opcode_t           disp_op,
  input  logic [1:0]        disp_src_rdy,
  input  tag_t [1:0]        disp_src_tag,
  input  word_t [1:0]       disp_src_data,
  input  robid_t            disp_robid,
  input  reg_t              disp_wa,
  output logic              disp_full_r,
  input  cdb_t              cdb_r,
  input  logic              iss_busy_r,
  output logic              iss_vld_r,
  output issue_t            iss_r
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [1:0] ST_ISSUED = 2'd3;

  typedef struct packed {
    opcode_t     op;
    logic [1:0]  rdy;
    tag_t [1:0]  tag;
    word_t [1:0] data;
    robid_t      robid;
    reg_t        wa;
  } entry_t;

  logic [1:0]   state_q [N];
  logic [1:0]   state_d [N];
  entry_t       entry_q [N];
  entry_t       entry_d [N];
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [N-1:0] older_q [N];
  logic [N-1:0] older_d [N];
  logic         iss_vld_q, iss_vld_d;
  logic         full_q, full_d;
  issue_t       iss_q, iss_d;

  logic [N-1:0]     oldest_rdy;
  logic             sel_vld, alloc_vld, do_issue, disp_acc;
  logic [IDX_W-1:0] sel_idx, alloc_idx;
  logic [IDX_W:0]   cnt;
  logic             unused_cdb;

  assign unused_cdb = ^{cdb_r.robid, cdb_r.wa};

  always_comb begin
    oldest_rdy = '0;
    for (int i = 0; i < N; i++) begin
      oldest_rdy[i] = (state_q[i] == ST_READY);
      for (int j = 0; j < N; j++)
        if (j != i && state_q[j] == ST_READY && older_q[j][i]) oldest_rdy[i] = 1'b0;
    end
  end

  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = '0;
    alloc_vld = 1'b0;
    alloc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (oldest_rdy[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (state_q[i] == ST_FREE) begin
        alloc_vld = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign do_issue = sel_vld & ~iss_busy_r & ~flush;
  assign disp_acc = disp_vld & ~full_q & alloc_vld & ~flush;

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    older_d   = older_q;
    iss_vld_d = do_issue;
    iss_d     = iss_q;
    cnt       = '0;

    if (do_issue) begin
      iss_d.op    = entry_q[sel_idx].op;
      iss_d.tag   = tag_t'(TAG_BASE) + tag_t'(sel_idx);
      iss_d.rdata = entry_q[sel_idx].data;
      iss_d.robid = entry_q[sel_idx].robid;
      iss_d.wa    = entry_q[sel_idx].wa;
    end

    for (int i = 0; i < N; i++) begin
      case (state_q[i])
        ST_WAIT: begin
          for (int k = 0; k < 2; k++)
            if (!entry_q[i].rdy[k] && cdb_r.vld && cdb_r.tag == entry_q[i].tag[k]) begin
              entry_d[i].rdy[k]  = 1'b1;
              entry_d[i].data[k] = cdb_r.wdata;
            end
          if (&entry_d[i].rdy) state_d[i] = ST_READY;
        end
        ST_READY:  if (do_issue && sel_idx == IDX_W'(i)) state_d[i] = ST_ISSUED;
        ST_ISSUED: if (cdb_r.vld && cdb_r.tag == tag_t'(TAG_BASE + i)) state_d[i] = ST_FREE;
        default: ;
      endcase
    end

    // allocation uses start-of-cycle occupancy, so a slot freed this cycle waits a cycle
    if (disp_acc) begin
      entry_d[alloc_idx].op    = disp_op;
      entry_d[alloc_idx].robid = disp_robid;
      entry_d[alloc_idx].wa    = disp_wa;
      for (int k = 0; k < 2; k++) begin
        entry_d[alloc_idx].tag[k]  = disp_src_tag[k];
        entry_d[alloc_idx].rdy[k]  = disp_src_rdy[k] | (cdb_r.vld && cdb_r.tag == disp_src_tag[k]);
        entry_d[alloc_idx].data[k] = disp_src_rdy[k] ? disp_src_data[k] : cdb_r.wdata;
      end
      state_d[alloc_idx] = (&entry_d[alloc_idx].rdy) ? ST_READY : ST_WAIT;
      older_d[alloc_idx] = '0;
      for (int j = 0; j < N; j++) older_d[j][alloc_idx] = (state_q[j] != ST_FREE);
    end

    if (flush)
      for (int i = 0; i < N; i++) state_d[i] = ST_FREE;

    for (int i = 0; i < N; i++)
      if (state_d[i] != ST_FREE) cnt = cnt + (IDX_W+1)'(1);
    full_d = (cnt == (IDX_W+1)'(N));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_FREE;
        entry_q[i] <= '0;
        older_q[i] <= '0;
      end
      iss_vld_q <= 1'b0;
      iss_q     <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      older_q   <= older_d;
      iss_vld_q <= iss_vld_d;
      iss_q     <= iss_d;
      full_q    <= full_d;
    end
  end

  assign disp_full_r = full_q;
  assign iss_vld_r   = iss_vld_q;
  assign iss_r       = iss_q;
endmodule

// File: tb/tb_tomasulo_rs_arith.sv
// Bench for tomasulo_rs_arith: directed scenarios plus random traffic, all checked
// cycle by cycle against an occupancy/sequence-number model of the station.
module tb_tomasulo_rs_arith;
  import tomasulo_rs_arith_pkg::*;

  localparam int N        = 4;
  localparam int TAG_BASE = 1;

  logic        clk = 1'b0;
  logic        rst, flush, disp_vld;
  opcode_t     disp_op;
  logic [1:0]  disp_src_rdy;
  tag_t [1:0]  disp_src_tag;
  word_t [1:0] disp_src_data;
  robid_t      disp_robid;
  reg_t        disp_wa;
  logic        disp_full_r;
  cdb_t        cdb_r;
  logic        iss_busy_r, iss_vld_r;
  issue_t      iss_r;

  tomasulo_rs_arith #(.N(N), .TAG_BASE(TAG_BASE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_vld(disp_vld), .disp_op(disp_op),
    .disp_src_rdy(disp_src_rdy), .disp_src_tag(disp_src_tag), .disp_src_data(disp_src_data),
    .disp_robid(disp_robid), .disp_wa(disp_wa), .disp_full_r(disp_full_r), .cdb_r(cdb_r),
    .iss_busy_r(iss_busy_r), .iss_vld_r(iss_vld_r), .iss_r(iss_r)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: occupied slots, issued flag, operands held, and a monotonic dispatch number
  bit       m_occ  [N];
  bit       m_iss  [N];
  bit [1:0] m_have [N];
  tag_t     m_tag  [N][2];
  word_t    m_data [N][2];
  opcode_t  m_op   [N];
  robid_t   m_rob  [N];
  reg_t     m_wa   [N];
  int       m_seq  [N];
  int       seq_ctr;
  bit       m_full;
  bit       e_vld;
  issue_t   e_iss;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; disp_vld = 1'b0; disp_op = '0; disp_src_rdy = '0;
    disp_src_tag = '0; disp_src_data = '0; disp_robid = '0; disp_wa = '0;
    cdb_r = '0; iss_busy_r = 1'b0;
  endtask

  task automatic disp(input opcode_t op, input logic [1:0] rdy, input tag_t t0, input tag_t t1,
                      input word_t d0, input word_t d1, input robid_t rob);
    disp_vld = 1'b1; disp_op = op; disp_src_rdy = rdy;
    disp_src_tag[0] = t0; disp_src_tag[1] = t1;
    disp_src_data[0] = d0; disp_src_data[1] = d1;
    disp_robid = rob; disp_wa = reg_t'(rob);
  endtask

  task automatic cdb(input tag_t t, input word_t w);
    cdb_r.vld = 1'b1; cdb_r.tag = t; cdb_r.wdata = w;
  endtask

  function automatic tag_t own_tag(input int i);
    return tag_t'(TAG_BASE + i);
  endfunction

  task automatic model_step();
    int sel, alloc, cnt;
    sel = -1; alloc = -1; cnt = 0;
    e_vld = 1'b0;
    if (rst || flush) begin
      for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
      if (rst) seq_ctr = 0;
      m_full = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_occ[i] && !m_iss[i] && m_have[i] == 2'b11 && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
      if (!m_occ[i] && alloc < 0) alloc = i;
    end
    if (sel >= 0 && !iss_busy_r) begin
      e_vld = 1'b1;
      e_iss = '0;
      e_iss.op = m_op[sel]; e_iss.tag = own_tag(sel);
      e_iss.rdata[0] = m_data[sel][0]; e_iss.rdata[1] = m_data[sel][1];
      e_iss.robid = m_rob[sel]; e_iss.wa = m_wa[sel];
    end
    for (int i = 0; i < N; i++) begin
      if (!m_occ[i] || !cdb_r.vld) continue;
      if (m_iss[i]) begin
        if (cdb_r.tag == own_tag(i)) m_occ[i] = 1'b0;
      end else begin
        for (int k = 0; k < 2; k++)
          if (!m_have[i][k] && m_tag[i][k] == cdb_r.tag) begin
            m_have[i][k] = 1'b1; m_data[i][k] = cdb_r.wdata;
          end
      end
    end
    if (e_vld) m_iss[sel] = 1'b1;
    if (disp_vld && !m_full && alloc >= 0) begin
      m_occ[alloc] = 1'b1; m_iss[alloc] = 1'b0;
      m_op[alloc] = disp_op; m_rob[alloc] = disp_robid; m_wa[alloc] = disp_wa;
      m_seq[alloc] = seq_ctr; seq_ctr++;
      for (int k = 0; k < 2; k++) begin
        m_tag[alloc][k] = disp_src_tag[k];
        if (disp_src_rdy[k]) begin
          m_have[alloc][k] = 1'b1; m_data[alloc][k] = disp_src_data[k];
        end else if (cdb_r.vld && cdb_r.tag == disp_src_tag[k]) begin
          m_have[alloc][k] = 1'b1; m_data[alloc][k] = cdb_r.wdata;
        end else m_have[alloc][k] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) if (m_occ[i]) cnt++;
    m_full = (cnt == N);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("iss_vld", iss_vld_r, e_vld);
    if (e_vld) check("iss_r", iss_r, e_iss);
    check("full", disp_full_r, m_full);
    idle();
  endtask

  initial begin
    idle();
    seq_ctr = 0;
    rst = 1'b1;
    tick();
    check("rst_iss_r", iss_r, '0);

    // both operands ready: issue two edges after dispatch
    disp(OP_ADD, 2'b11, 0, 0, 5, 7, 1); tick();
    check("t1_early", iss_vld_r, 1'b0);
    tick();
    check("t1_vld", iss_vld_r, 1'b1);
    check("t1_rdata", iss_r.rdata, {32'd7, 32'd5});
    check("t1_tag", iss_r.tag, TAG_BASE);
    cdb(1, 0); tick();
    disp(OP_ADD, 2'b11, 0, 0, 1, 2, 2); tick(); tick();
    check("t1_reuse_tag", iss_r.tag, 1);
    cdb(1, 0); tick();

    // operand captured from CDB
    disp(OP_SUB, 2'b10, 3, 0, 0, 2, 3); tick();
    cdb(3, 10); tick();
    check("t2_wait", iss_vld_r, 1'b0);
    tick();
    check("t2_vld", iss_vld_r, 1'b1);
    check("t2_rdata", iss_r.rdata, {32'd2, 32'd10});
    cdb(1, 0); tick();

    // dispatch-cycle bypass
    disp(OP_MOV, 2'b10, 3, 0, 0, 4, 4); cdb(3, 9); tick();
    check("t3_wait", iss_vld_r, 1'b0);
    tick();
    check("t3_vld", iss_vld_r, 1'b1);
    check("t3_src0", iss_r.rdata[0], 9);
    cdb(1, 0); tick();

    // fill, ignored dispatch, release one slot, reuse that slot
    for (int i = 0; i < N; i++) begin
      disp(OP_ADD, 2'b10, 9, 0, 0, word_t'(i), robid_t'(10 + i)); tick();
    end
    check("t4_full", disp_full_r, 1'b1);
    disp(OP_ADD, 2'b11, 0, 0, 1, 1, 20); tick();
    check("t4_still_full", disp_full_r, 1'b1);
    cdb(9, 1); tick();
    for (int i = 0; i < N; i++) begin
      tick();
      check("t4_order", iss_r.tag, own_tag(i));
    end
    cdb(2, 0); tick();
    check("t4_not_full", disp_full_r, 1'b0);
    disp(OP_SUB, 2'b11, 0, 0, 3, 3, 21); tick(); tick();
    check("t4_slot_tag", iss_r.tag, 2);
    check("t4_slot_rob", iss_r.robid, 21);
    cdb(1, 0); tick(); cdb(3, 0); tick(); cdb(4, 0); tick(); cdb(2, 0); tick();

    // three READY together under busy, then in-order back-to-back issue
    for (int i = 0; i < 3; i++) begin
      disp(OP_ADD, 2'b01, 0, 9, word_t'(i), 0, robid_t'(i)); iss_busy_r = 1'b1; tick();
    end
    cdb(9, 5); iss_busy_r = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      iss_busy_r = 1'b1; tick();
      check("t5_busy", iss_vld_r, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_vld", iss_vld_r, 1'b1);
      check("t5_order", iss_r.tag, own_tag(i));
    end
    cdb(1, 0); tick(); cdb(2, 0); tick(); cdb(3, 0); tick();

    // flush with mixed states
    disp(OP_ADD, 2'b11, 0, 0, 1, 1, 30); tick();
    disp(OP_ADD, 2'b10, 9, 0, 0, 1, 31); tick();
    disp(OP_ADD, 2'b11, 0, 0, 2, 2, 0); tick();
    flush = 1'b1; disp(OP_ADD, 2'b11, 0, 0, 7, 7, 7); tick();
    check("t6_full", disp_full_r, 1'b0);
    check("t6_vld", iss_vld_r, 1'b0);
    cdb(1, 0); tick();
    check("t6_stale_cdb", iss_vld_r, 1'b0);
    disp(OP_MOV, 2'b11, 0, 0, 6, 6, 31); tick(); tick();
    check("t6_realloc_tag", iss_r.tag, 1);
    check("t6_realloc_rob", iss_r.robid, 31);
    cdb(1, 0); tick();

    // reset mid-operation
    disp(OP_ADD, 2'b11, 0, 0, 1, 1, 1); tick();
    disp(OP_ADD, 2'b11, 0, 0, 1, 1, 2); tick();
    rst = 1'b1; cdb(1, 0); tick();
    check("t7_vld", iss_vld_r, 1'b0);
    check("t7_iss_r", iss_r, '0);
    cdb(2, 0); tick();
    check("t7_stale", iss_vld_r, 1'b0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int r, start;
      if ($urandom_range(0, 1) == 1)
        disp(opcode_t'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             tag_t'($urandom_range(1, 8)), tag_t'($urandom_range(1, 8)),
             $urandom, $urandom, robid_t'($urandom_range(0, 31)));
      iss_busy_r = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 59) == 0);
      r = $urandom_range(0, 9);
      start = $urandom_range(0, N - 1);
      if (r < 5) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (start + k) % N;
          if (m_occ[i] && m_iss[i]) begin
            cdb(own_tag(i), $urandom);
            break;
          end
        end
      end else if (r < 8) cdb(tag_t'($urandom_range(1, 8)), $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
